regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles RdAddr is held stable before RdData is sampled; legal range 1-15.
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 ResetL  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  request a sweep; sampled only in IDLE.
REQ-005 FirstReg  input  5  first register index of the sweep; captured when Start is accepted.
REQ-006 LastReg  input  5  last register index of the sweep; captured when Start is accepted.
REQ-007 RdAddr  output  5  register read address; drives the register file read-port address.
REQ-008 RdData  input  64  register file read-port data (asynchronous read).
REQ-009 OutData  output  64  captured register value.
REQ-010 OutAddr  output  5  index of the register carried in OutData.
REQ-011 OutValid  output  1  OutData/OutAddr valid.
REQ-012 OutReady  input  1  downstream accepts the beat.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse at sweep completion.
REQ-015 Checksum  output  64  XOR of all beats emitted in the current or last sweep.

Function
REQ-016 FSM states: IDLE, SETTLE, SEND, DONE.
REQ-017 IDLE with Start=1: latch FirstReg/LastReg, set cur=FirstReg, RdAddr=FirstReg, clear Checksum, load the settle counter with SETTLE, go to SETTLE.
REQ-018 SETTLE decrements the counter each cycle; on the cycle it reaches 0, OutData is loaded from RdData (or zero, per REQ-019), OutAddr=cur, OutValid=1, and the FSM goes to SEND.
REQ-019 Index 31 is the zero register: when cur=31, OutData=0 regardless of RdData.
REQ-020 SEND holds OutValid, OutData and OutAddr stable until a handshake occurs (OutValid=1 and OutReady=1 at a posedge).
REQ-021 On handshake: Checksum ^= OutData; OutValid deasserts the next cycle.
REQ-022 On handshake, if cur==LastReg, go to DONE; otherwise set cur=(cur+1) mod 32 and RdAddr=cur+1, reload the settle counter, and go to SETTLE.
REQ-023 Wrap-around: if FirstReg>LastReg, the sweep runs FirstReg..31, then 0..LastReg; FirstReg==LastReg yields exactly one beat.
REQ-024 DONE asserts Done for exactly one cycle, then goes to IDLE; Checksum holds its value until the next accepted Start.
REQ-025 Start while Busy=1 is ignored; FirstReg/LastReg changes during a sweep have no effect.
REQ-026 Per-beat latency: RdAddr change to OutValid rise = SETTLE+1 cycles; Start to first OutValid = SETTLE+1 cycles.
REQ-027 OutReady may be held high continuously; throughput is then 1 beat per SETTLE+1 cycles.
REQ-028 RdAddr holds its last value in IDLE.

Reset
REQ-029 ResetL=0 forces immediately, independent of Clk: state=IDLE, RdAddr=0, OutData=0, OutAddr=0, OutValid=0, Busy=0, Done=0, Checksum=0, settle counter=0.
REQ-030 Reset mid-sweep abandons the sweep with no Done pulse; after ResetL rises, the first Start is accepted normally.

Structure
REQ-031 The FSM state encoding, the zero-register index (31), and the register-index width (5) belong in the shared CPU package; the data width (64) is taken from the package.
REQ-032 Single module with no sub-modules; the settle counter is inline.

Verification
REQ-033 Regfile model holding regs[i]=i*0x1111; SETTLE=1; Start with First=0, Last=3; OutReady=1 -> beats 0x0, 0x1111, 0x2222, 0x3333 with OutAddr 0-3, a beat every 2 cycles, Done pulse, Checksum=0x0.
REQ-034 Same model; First=29, Last=1 -> OutAddr sequence 29, 30, 31, 0, 1; beat for 31 has OutData=0 even when the model returns 0xDEADBEEF for index 31.
REQ-035 Backpressure: OutReady low for 5 cycles in the first SEND -> OutValid, OutData and OutAddr stable throughout; no duplicate or dropped beats.
REQ-036 Start pulsed in the middle of a 0..7 sweep -> ignored; exactly 8 beats and 1 Done.
REQ-037 ResetL=0 asynchronously between clock edges during a SEND at reg 5 -> all outputs zero immediately; no Done; a subsequent First=Last=5 sweep -> 1 beat with 0x5555, Checksum=0x5555.
REQ-038 SETTLE=3 -> first OutValid exactly 4 cycles after Start is accepted; RdAddr is stable throughout each settle window.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared CPU definitions for the register-file dump engine:
// FSM encoding, register-index width, zero-register index and data width.
package regfile_dump_pkg;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned DataW   = 64;

    localparam logic [RegIdxW-1:0] ZeroReg = 5'd31;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSend   = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Sweeps a register range through an async-read register file port and streams
// each value out on a valid/ready interface, keeping a running XOR checksum.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [RegIdxW-1:0] i_first_reg,
    input  logic [RegIdxW-1:0] i_last_reg,
    output logic [RegIdxW-1:0] o_rd_addr,
    input  logic [DataW-1:0]   i_rd_data,
    output logic [DataW-1:0]   o_out_data,
    output logic [RegIdxW-1:0] o_out_addr,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [DataW-1:0]   o_checksum
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE);

    state_e             r_state, w_state;
    logic [3:0]         r_cnt, w_cnt;
    logic [RegIdxW-1:0] r_cur, w_cur;
    logic [RegIdxW-1:0] r_last, w_last;
    logic [RegIdxW-1:0] r_rd_addr, w_rd_addr;
    logic [DataW-1:0]   r_out_data, w_out_data;
    logic [RegIdxW-1:0] r_out_addr, w_out_addr;
    logic               r_out_valid, w_out_valid;
    logic [DataW-1:0]   r_checksum, w_checksum;
    logic               w_handshake;

    assign w_handshake = r_out_valid & i_out_ready;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cur       = r_cur;
        w_last      = r_last;
        w_rd_addr   = r_rd_addr;
        w_out_data  = r_out_data;
        w_out_addr  = r_out_addr;
        w_out_valid = r_out_valid;
        w_checksum  = r_checksum;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_cur      = i_first_reg;
                    w_last     = i_last_reg;
                    w_rd_addr  = i_first_reg;
                    w_checksum = '0;
                    w_cnt      = SettleLoad;
                    w_state    = StSettle;
                end
            end
            StSettle: begin
                // Capture on the edge where the counter hits zero, not one cycle after.
                if (r_cnt <= 4'd1) begin
                    w_cnt       = '0;
                    w_out_data  = (r_cur == ZeroReg) ? '0 : i_rd_data;
                    w_out_addr  = r_cur;
                    w_out_valid = 1'b1;
                    w_state     = StSend;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            StSend: begin
                if (w_handshake) begin
                    w_checksum  = r_checksum ^ r_out_data;
                    w_out_valid = 1'b0;
                    if (r_cur == r_last) begin
                        w_state = StDone;
                    end else begin
                        w_cur     = r_cur + RegIdxW'(1);
                        w_rd_addr = r_cur + RegIdxW'(1);
                        w_cnt     = SettleLoad;
                        w_state   = StSettle;
                    end
                end
            end
            StDone: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_cur       <= '0;
            r_last      <= '0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cur       <= w_cur;
            r_last      <= w_last;
            r_rd_addr   <= w_rd_addr;
            r_out_data  <= w_out_data;
            r_out_addr  <= w_out_addr;
            r_out_valid <= w_out_valid;
            r_checksum  <= w_checksum;
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_out_valid = r_out_valid;
    assign o_checksum  = r_checksum;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: two instances (SETTLE=1 and SETTLE=3) against a
// register-file model holding regs[i] = i*0x1111, with 0xDEADBEEF at index 31.
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] out_data;
    logic [4:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [63:0] checksum;

    logic        start3;
    logic [4:0]  rd_addr3;
    logic [63:0] rd_data3;
    logic [63:0] out_data3;
    logic [4:0]  out_addr3;
    logic        out_valid3;
    logic        busy3;
    logic        done3;
    logic [63:0] checksum3;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [4:0]  q_addr[$];
    logic [63:0] q_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_data  = (rd_addr == 5'd31) ? 64'hDEAD_BEEF : 64'(rd_addr) * 64'h1111;
    assign rd_data3 = (rd_addr3 == 5'd31) ? 64'hDEAD_BEEF : 64'(rd_addr3) * 64'h1111;

    regfile_dump #(.SETTLE(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_first_reg (first_reg),
        .i_last_reg  (last_reg),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_out_data  (out_data),
        .o_out_addr  (out_addr),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_checksum  (checksum)
    );

    regfile_dump #(.SETTLE(3)) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start3),
        .i_first_reg (first_reg),
        .i_last_reg  (last_reg),
        .o_rd_addr   (rd_addr3),
        .i_rd_data   (rd_data3),
        .o_out_data  (out_data3),
        .o_out_addr  (out_addr3),
        .o_out_valid (out_valid3),
        .i_out_ready (1'b1),
        .o_busy      (busy3),
        .o_done      (done3),
        .o_checksum  (checksum3)
    );

    // Accepted beats and Done pulses on the SETTLE=1 instance.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_addr.push_back(out_addr);
            q_data.push_back(out_data);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200 && busy; c++) step();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    int          exp_a[5] = '{29, 30, 31, 0, 1};
    logic [63:0] exp_d;
    logic [63:0] exp_ck;
    int          base;
    int          d0;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start3    = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_checksum", checksum, 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Basic 0..3 sweep, ready held high: one beat every 2 cycles.
        base = q_addr.size();
        d0 = done_cnt;
        first_reg = 5'd0;
        last_reg  = 5'd3;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_settle", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_addr", 64'(out_addr), 64'(i));
            chk("t1_data", out_data, 64'(i) * 64'h1111);
            step();
            chk("t1_gap", 64'(out_valid), 64'd0);
        end
        chk("t1_done", 64'(done), 64'd1);
        step();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_checksum", checksum, 64'h0);
        chk("t1_rd_addr_hold", 64'(rd_addr), 64'd3);
        chk("t1_beats", 64'(q_addr.size() - base), 64'd4);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Wrap-around 29..1 with index 31 forced to zero.
        base = q_addr.size();
        first_reg = 5'd29;
        last_reg  = 5'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        chk("t2_beats", 64'(q_addr.size() - base), 64'd5);
        exp_ck = '0;
        for (int i = 0; i < 5; i++) begin
            exp_d = (exp_a[i] == 31) ? 64'h0 : 64'(exp_a[i]) * 64'h1111;
            exp_ck ^= exp_d;
            if (q_addr.size() > base + i) begin
                chk("t2_addr", 64'(q_addr[base+i]), 64'(exp_a[i]));
                chk("t2_data", q_data[base+i], exp_d);
            end
        end
        chk("t2_checksum", checksum, exp_ck);

        // Backpressure: first beat held for 5 cycles.
        base = q_addr.size();
        first_reg = 5'd2;
        last_reg  = 5'd3;
        out_ready = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_addr", 64'(out_addr), 64'd2);
            chk("t3_hold_data", out_data, 64'h2222);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t3_after_hs", 64'(out_valid), 64'd0);
        wait_idle();
        chk("t3_beats", 64'(q_addr.size() - base), 64'd2);
        if (q_addr.size() >= base + 2) begin
            chk("t3_beat0", 64'(q_addr[base]), 64'd2);
            chk("t3_beat1", 64'(q_addr[base+1]), 64'd3);
        end
        chk("t3_checksum", checksum, 64'h2222 ^ 64'h3333);

        // Start pulsed mid-sweep is ignored.
        base = q_addr.size();
        d0 = done_cnt;
        first_reg = 5'd0;
        last_reg  = 5'd7;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        first_reg = 5'd20;
        last_reg  = 5'd25;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        chk("t4_beats", 64'(q_addr.size() - base), 64'd8);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        if (q_addr.size() >= base + 8) begin
            chk("t4_last_addr", 64'(q_addr[base+7]), 64'd7);
            chk("t4_last_data", q_data[base+7], 64'h7777);
        end

        // Asynchronous reset during SEND at register 5.
        d0 = done_cnt;
        first_reg = 5'd5;
        last_reg  = 5'd9;
        out_ready = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_in_send", 64'(out_addr), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_data", out_data, 64'd0);
        chk("t5_rst_addr", 64'(out_addr), 64'd0);
        chk("t5_rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_checksum", checksum, 64'd0);
        #2 rst_n = 1'b1;
        step();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        base = q_addr.size();
        last_reg  = 5'd5;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        chk("t5_beats", 64'(q_addr.size() - base), 64'd1);
        if (q_addr.size() > base) chk("t5_data", q_data[base], 64'h5555);
        chk("t5_checksum", checksum, 64'h5555);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

        // SETTLE=3: first OutValid on the 4th edge from Start, RdAddr steady.
        first_reg = 5'd4;
        last_reg  = 5'd4;
        start3    = 1'b1;
        step();
        start3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t6_settle_valid", 64'(out_valid3), 64'd0);
            chk("t6_settle_rd_addr", 64'(rd_addr3), 64'd4);
            step();
        end
        chk("t6_settle_valid", 64'(out_valid3), 64'd0);
        step();
        chk("t6_valid", 64'(out_valid3), 64'd1);
        chk("t6_data", out_data3, 64'h4444);
        chk("t6_rd_addr", 64'(rd_addr3), 64'd4);
        step();
        step();
        chk("t6_idle", 64'(busy3), 64'd0);
        chk("t6_checksum", checksum3, 64'h4444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
